// File: rtl/ps2_host_cmd_ctrl.sv
`timescale 1ns/1ps
// PS/2 host-to-device command sequencer: inhibit, request-to-send, frame shift,
// ACK capture and timeout, driving open-drain line enables and returning a status.
module ps2_host_cmd_ctrl #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_status,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit,
    output logic       busy
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SEND      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
    localparam logic [2:0] ST_RESP      = 3'd6;

    localparam logic [1:0] STS_TIMEOUT = 2'd2;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       bitcnt_r, bitcnt_s;
    logic [9:0]       shift_r, shift_s;
    logic [1:0]       status_s;
    logic             clk_oe_s, dat_oe_s;
    logic [2:0]       clk_sync_r;
    logic [1:0]       dat_sync_r;
    logic             fall_s, timeout_s;
    logic             cmd_ready_r, rsp_valid_r, busy_r, clk_oe_r, dat_oe_r;
    logic [1:0]       rsp_status_r;

    assign fall_s    = clk_sync_r[2] & ~clk_sync_r[1];
    assign timeout_s = (cnt_r == TMO_LAST);

    // Pin synchronizers; idle-high reset value avoids a phantom fall after reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_sync_r <= 3'b111;
            dat_sync_r <= 2'b11;
        end else begin
            clk_sync_r <= {clk_sync_r[1:0], ps2_clk_i};
            dat_sync_r <= {dat_sync_r[0], ps2_dat_i};
        end
    end

    // Next-state and next-output logic of the transmit sequencer.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        bitcnt_s = bitcnt_r;
        shift_s  = shift_r;
        status_s = rsp_status_r;
        clk_oe_s = clk_oe_r;
        dat_oe_s = dat_oe_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    state_s  = ST_INHIBIT;
                    shift_s  = {1'b1, odd_parity(cmd_data), cmd_data};
                    bitcnt_s = 4'd0;
                    cnt_s    = '0;
                    clk_oe_s = 1'b1;
                    dat_oe_s = 1'b0;
                end else begin
                    clk_oe_s = 1'b0;
                    dat_oe_s = 1'b0;
                end
            end
            ST_INHIBIT: begin
                clk_oe_s = 1'b1;
                if (cnt_r == INH_LAST) begin
                    state_s  = ST_RTS;
                    cnt_s    = '0;
                    dat_oe_s = 1'b1;
                end else begin
                    cnt_s    = cnt_r + 1'b1;
                    dat_oe_s = 1'b0;
                end
            end
            ST_RTS: begin
                // Release clock, keep data low as the start bit.
                state_s  = ST_SEND;
                cnt_s    = '0;
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b1;
            end
            ST_SEND: begin
                if (timeout_s) begin
                    state_s  = ST_RESP;
                    status_s = STS_TIMEOUT;
                    clk_oe_s = 1'b0;
                    dat_oe_s = 1'b0;
                end else if (fall_s) begin
                    cnt_s    = cnt_r + 1'b1;
                    dat_oe_s = ~shift_r[0];
                    shift_s  = {1'b0, shift_r[9:1]};
                    bitcnt_s = bitcnt_r + 4'd1;
                    state_s  = (bitcnt_r == 4'd9) ? ST_ACK : ST_SEND;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_ACK: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                if (timeout_s) begin
                    state_s  = ST_RESP;
                    status_s = STS_TIMEOUT;
                end else if (fall_s) begin
                    cnt_s    = cnt_r + 1'b1;
                    status_s = {1'b0, dat_sync_r[1]};
                    state_s  = ST_WAIT_IDLE;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                if (timeout_s) begin
                    state_s  = ST_RESP;
                    status_s = STS_TIMEOUT;
                end else if (clk_sync_r[1] && dat_sync_r[1]) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            ST_RESP: begin
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                clk_oe_s = 1'b0;
                dat_oe_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            bitcnt_r     <= 4'd0;
            shift_r      <= 10'd0;
            rsp_status_r <= 2'd0;
            clk_oe_r     <= 1'b0;
            dat_oe_r     <= 1'b0;
            cmd_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bitcnt_r     <= bitcnt_s;
            shift_r      <= shift_s;
            rsp_status_r <= status_s;
            clk_oe_r     <= clk_oe_s;
            dat_oe_r     <= dat_oe_s;
            cmd_ready_r  <= (state_s == ST_IDLE);
            rsp_valid_r  <= (state_s == ST_RESP);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_status = rsp_status_r;
    assign ps2_clk_oe = clk_oe_r;
    assign ps2_dat_oe = dat_oe_r;
    assign busy       = busy_r;
    assign rx_inhibit = busy_r;

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
`timescale 1ns/1ps
// Bench for ps2_host_cmd_ctrl: a behavioural PS/2 device clocks frames out of the
// host asynchronously; frames, timing and status are checked against a reference model.
module tb_ps2_host_cmd_ctrl;

    localparam int INH = 20;
    localparam int TMO = 500;

    logic       clock = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_status;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       rx_inhibit;
    logic       busy;

    logic        dev_clk = 1'b1;
    logic        dev_dat = 1'b1;
    logic [10:0] frame_q;
    int          n_cmp = 0;
    int          n_err = 0;

    // Open-drain wired-AND of host and device on both lines.
    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    always #5 clock = ~clock;

    ps2_host_cmd_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .rx_inhibit(rx_inhibit), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Line levels the device should see: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    function automatic logic [1:0] ref_status(input logic ack_high, input logic timed_out);
        if (timed_out) return 2'd2;
        return ack_high ? 2'd1 : 2'd0;
    endfunction

    // Called on a negedge; offers a byte, checks inhibit/RTS timing, returns at SEND entry.
    task automatic start_cmd(input logic [7:0] b, input logic hold, input logic [7:0] next_b);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        check("accept_wait", n < 100, 1);
        @(negedge clock);
        check("accept_busy", {busy, rx_inhibit, cmd_ready}, 3'b110);
        cmd_valid = hold;
        cmd_data  = hold ? next_b : 8'($urandom);
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < INH + 10) begin
            n++;
            @(negedge clock);
        end
        check("inhibit_len", n, INH);
        check("rts_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
        @(negedge clock);
        check("send_entry", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
    endtask

    // Device: clocks n_pulses, sampling data just before each fall; the 11th is the ACK pulse.
    task automatic device_clock(input int n_pulses, input logic ack_high, input int hp);
        int guard = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && guard < 2000) begin
            @(posedge clock);
            guard++;
        end
        check("dev_rts_seen", guard < 2000, 1);
        @(posedge clock);
        #2.3;
        frame_q = '0;
        for (int i = 0; i < n_pulses; i++) begin
            #(hp);
            if (i < 11) frame_q[i] = ps2_dat_i;
            if (i == 10) begin
                dev_dat = ack_high;
                #(hp / 4);
            end
            dev_clk = 1'b0;
            #(hp);
            dev_clk = 1'b1;
        end
        dev_dat = 1'b1;
    endtask

    task automatic finish_rsp(input logic [1:0] exp, input int delay);
        int n = 0;
        @(negedge clock);
        while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clock); n++; end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_status", rsp_status, exp);
        for (int i = 0; i < delay; i++) begin
            @(negedge clock);
            check("rsp_hold", {rsp_valid, rsp_status, cmd_ready, busy}, {1'b1, exp, 1'b0, 1'b1});
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check("rsp_done", {rsp_valid, busy, rx_inhibit, cmd_ready, ps2_clk_oe, ps2_dat_oe}, 6'b000100);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        logic [7:0] b;
        logic     ack;
        int       hp;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_state", {cmd_ready, rsp_valid, rsp_status, ps2_clk_oe, ps2_dat_oe, rx_inhibit, busy},
              8'b1000_0000);
        resetn = 1'b1;
        @(negedge clock);

        // 0xED acknowledged by the device
        start_cmd(8'hED, 1'b0, 8'h00);
        device_clock(11, 1'b0, 100);
        check("frame_ED", frame_q, ref_frame(8'hED));
        finish_rsp(ref_status(1'b0, 1'b0), 3);

        // 0xFF with data left high at the ACK fall
        start_cmd(8'hFF, 1'b0, 8'h00);
        device_clock(11, 1'b1, 100);
        check("frame_FF", frame_q, ref_frame(8'hFF));
        finish_rsp(ref_status(1'b1, 1'b0), 1);

        // 0xF4 with a silent device
        start_cmd(8'hF4, 1'b0, 8'h00);
        n = 0;
        while (rsp_valid !== 1'b1 && n < TMO + 20) begin @(negedge clock); n++; end
        check("tmo_latency", n, TMO);
        check("tmo_lines", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        finish_rsp(ref_status(1'b1, 1'b1), 2);

        // reset in the middle of the data bits
        start_cmd(8'hA5, 1'b0, 8'h00);
        device_clock(5, 1'b0, 90);
        @(negedge clock);
        check("pre_reset_busy", {busy, ps2_dat_oe}, 2'b11);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check("reset_mid", {ps2_clk_oe, ps2_dat_oe, busy, rx_inhibit, cmd_ready, rsp_valid}, 6'b000010);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        start_cmd(8'h00, 1'b0, 8'h00);
        device_clock(11, 1'b0, 70);
        check("frame_00", frame_q, ref_frame(8'h00));
        finish_rsp(ref_status(1'b0, 1'b0), 1);

        // second byte held on cmd_valid through the whole transfer and response
        start_cmd(8'h12, 1'b1, 8'h34);
        device_clock(11, 1'b0, 80);
        check("frame_12", frame_q, ref_frame(8'h12));
        finish_rsp(ref_status(1'b0, 1'b0), 5);
        start_cmd(8'h34, 1'b0, 8'h00);
        device_clock(11, 1'b1, 80);
        check("frame_34", frame_q, ref_frame(8'h34));
        finish_rsp(ref_status(1'b1, 1'b0), 0);

        // randomized bytes, ACK levels and asynchronous device periods
        for (int k = 0; k < 8; k++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            hp  = int'($urandom_range(60, 110));
            start_cmd(b, 1'b0, 8'h00);
            device_clock(11, ack, hp);
            check("frame_rand", frame_q, ref_frame(b));
            finish_rsp(ref_status(ack, 1'b0), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
